// File: rtl/uart_pkg.sv
// Shared types and constants for the UART burst transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        NEXT,
        DONE
    } state_t;

    localparam int CLKS_115200 = 868;
    localparam int CLKS_9600   = 10416;

    function automatic int frame_bits(input int dw, input int pe, input int sb);
        return 1 + dw + pe + sb;
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// Frame serialiser: start bit, data LSB first, optional parity, stop bits.
// Owns the baud and bit counters; TXD is registered.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = CLKS_115200,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    input  logic              par,
    output logic              txd,
    output logic              frame_end
);

    localparam int FRAME = frame_bits(DATA_W, PARITY_EN, STOP_BITS);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(FRAME);

    logic [FRAME-1:0] sh;
    logic [FRAME-1:0] frame;
    logic [CNT_W-1:0] cnt;
    logic [BIT_W-1:0] bitn;
    logic             active;
    logic             bit_end;

    always_comb begin
        frame           = '1;
        frame[0]        = 1'b0;
        frame[DATA_W:1] = data;
        if (PARITY_EN != 0) frame[DATA_W+1] = par;
    end

    assign bit_end   = active && (cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign frame_end = bit_end && (bitn == BIT_W'(FRAME - 1));

    // The output register lags the shifter by one cycle, so the sequencer's
    // NEXT cycle overlaps the last stop-bit cycle on the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh     <= '1;
            cnt    <= '0;
            bitn   <= '0;
            active <= 1'b0;
            txd    <= 1'b1;
        end else begin
            txd <= active ? sh[0] : 1'b1;
            if (load) begin
                sh     <= frame;
                cnt    <= '0;
                bitn   <= '0;
                active <= 1'b1;
            end else if (bit_end) begin
                sh   <= {1'b1, sh[FRAME-1:1]};
                cnt  <= '0;
                bitn <= bitn + 1'b1;
                if (frame_end) active <= 1'b0;
            end else if (active) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_burst_tx.sv
// Burst UART transmitter: byte buffer, sequencer FSM, abort latch,
// one-shot and repeat modes on top of uart_tx_core.
module uart_burst_tx
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int CLKS_PER_BIT = CLKS_115200,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              CLK100MHZ,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W:0]   len,
    input  logic              start,
    input  logic              repeat_en,
    input  logic              abort,
    output logic              TXD,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] byte_idx
);

    state_t            st;
    state_t            nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W:0]   len_q;
    logic              rep_q;
    logic              abort_q;
    logic              zdone_q;
    logic              accept;
    logic              last;
    logic              stop_now;
    logic              core_load;
    logic              frame_end;

    always_ff @(posedge CLK100MHZ) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Asynchronous read: a same-edge write lands after the fetch.
    assign rd       = mem[idx];
    assign accept   = (st == IDLE) && start && (len != '0);
    assign last     = ({1'b0, idx} == len_q - 1'b1);
    assign stop_now = abort_q || abort || (last && !rep_q);

    always_comb begin
        nxt       = st;
        core_load = 1'b0;
        unique case (st)
            IDLE: if (accept) nxt = LOAD;
            LOAD: begin
                core_load = 1'b1;
                nxt       = SEND;
            end
            SEND: if (frame_end) nxt = NEXT;
            NEXT: nxt = stop_now ? DONE : LOAD;
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            st      <= IDLE;
            idx     <= '0;
            len_q   <= '0;
            rep_q   <= 1'b0;
            abort_q <= 1'b0;
            zdone_q <= 1'b0;
        end else begin
            st      <= nxt;
            zdone_q <= (st == IDLE) && start && (len == '0);
            if (accept) begin
                idx   <= '0;
                len_q <= len;
                rep_q <= repeat_en;
            end else if (st == NEXT && !stop_now) begin
                idx <= last ? '0 : idx + 1'b1;
            end
            if (st == IDLE) abort_q <= 1'b0;
            else if (busy && abort) abort_q <= 1'b1;
        end
    end

    assign busy     = (st == LOAD) || (st == SEND) || (st == NEXT);
    assign done     = (st == DONE) || zdone_q;
    assign byte_idx = idx;

    uart_tx_core #(
        .DATA_W      (DATA_W),
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .PARITY_EN   (PARITY_EN),
        .STOP_BITS   (STOP_BITS)
    ) u_core (
        .clk      (CLK100MHZ),
        .rst      (reset),
        .load     (core_load),
        .data     (rd),
        .par      (^rd),
        .txd      (TXD),
        .frame_end(frame_end)
    );

endmodule

// File: doc/uart_burst_tx.md
Name: uart_burst_tx

Overview:
Parametrised UART transmit sequencer. Holds a writable byte buffer and, on command, serialises the first `len` entries onto TXD. Each byte is sent as an 8N1/8E1-style frame, parametrised in data width, buffer depth, baud divisor, parity and stop bits. Adds one-shot and continuous-repeat modes, a graceful abort, and busy/done status. Sits between the host-side test logic (switches/PC loader) and the board TXD pin.

Parameters:
DATA_W, 8, bits per character (5..9)
DEPTH, 16, buffer entries (power of two)
ADDR_W, 4, log2(DEPTH)
CLKS_PER_BIT, 868, CLK100MHZ cycles per bit (115200 baud); must be >= 2
PARITY_EN, 0, 1 = append even-parity bit after data
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
CLK100MHZ  in  1  system clock, all logic rising-edge
reset  in  1  asynchronous, active-high reset
wr_en  in  1  buffer write strobe
wr_addr  in  ADDR_W  buffer write address
wr_data  in  DATA_W  buffer write data
len  in  ADDR_W+1  bytes per burst, 0..DEPTH; sampled at start acceptance
start  in  1  level; accepted on any rising clock edge in IDLE
repeat_en  in  1  sampled at start acceptance; 1 = loop the burst indefinitely
abort  in  1  request stop after the current frame completes
TXD  out  1  serial line, idle high
busy  out  1  high from accept until the final stop bit ends
done  out  1  single-cycle pulse at end of burst (normal or aborted)
byte_idx  out  ADDR_W  index of the byte currently on the line

Behaviour:
- Reset values: TXD=1, busy=0, done=0, byte_idx=0, FSM=IDLE. Buffer RAM is not reset.
- Reset mid-frame: TXD returns to 1 asynchronously. The partial frame is discarded; no done pulse.
- FSM states:
  - IDLE -> LOAD on start && len!=0.
  - IDLE -> IDLE on start && len==0; done pulses next cycle, busy stays 0.
  - LOAD (1 cycle, TXD=1): read buf[idx], compute parity -> SEND.
  - SEND: start bit (0), DATA_W data bits LSB first, parity bit if PARITY_EN, STOP_BITS stop bits (1). Each bit lasts exactly CLKS_PER_BIT cycles.
  - At end of last stop bit -> NEXT.
  - NEXT (1 cycle):
    - if abort_latched -> DONE.
    - elif idx==len_q-1 && !rep_q -> DONE.
    - elif idx==len_q-1 -> idx=0, LOAD.
    - else idx++, LOAD.
  - DONE (1 cycle): done=1, busy=0 next -> IDLE.
- Latency: start accepted at edge k -> busy=1 after k. LOAD at k+1. TXD falls after edge k+2.
- Inter-frame gap: exactly 2 idle-high cycles (NEXT, LOAD) after the final stop bit.
- len, repeat_en captured into len_q/rep_q at accept; later changes are ignored until the next burst.
- start while busy: ignored. No queueing.
- abort: latched on any cycle while busy; cleared at IDLE. Never truncates a frame. abort in IDLE is ignored.
- Buffer writes allowed at any time. The byte is fetched at LOAD; simultaneous write to the fetched address returns old data (read-first).
- Parity: even parity, i.e. XOR of data bits.
- Frame length (bits): 1 + DATA_W + PARITY_EN + STOP_BITS.
- Baud counter and bit counter are both owned by the serialiser.
- byte_idx is valid while busy and holds its last value otherwise.

Decomposition:
- Package uart_pkg:
  - FSM state localparams (IDLE, LOAD, SEND, NEXT, DONE)
  - frame-length constant function
  - default baud divisor constants: 868 for 115200, 10416 for 9600
- Sub-module uart_tx_core: baud counter plus shift register.
  - Interface: load/data in, TXD out, frame_end pulse out.
  - Parameters: DATA_W, CLKS_PER_BIT, PARITY_EN, STOP_BITS.
- Top level: buffer RAM (inferred), sequencer FSM, abort latch.

Test Plan (bench uses CLKS_PER_BIT=4):
- Write A1,B2,C3,D4 to addr 0..3; len=4, start pulse -> 4 frames decode to A1,B2,C3,D4, each 40 cycles of bits; 2-cycle high gap between frames; done pulses once; busy low after.
- len=0, start -> busy never rises; done pulses one cycle after accept; TXD stays 1.
- repeat_en=1, len=2 (buf 55,AA) -> sequence 55,AA,55,AA...; assert abort mid-3rd frame -> 3rd frame completes fully, then done, no 4th start bit.
- PARITY_EN=1, STOP_BITS=2, byte 07 -> frame 0,1,1,1,0,0,0,0,0,1(parity),1,1; 48 cycles.
- Reset asserted mid-data-bit of frame 2 -> TXD=1 same cycle; busy=0; no done pulse; a new start after release sends from index 0.
- start held high through a whole burst -> exactly one burst per IDLE visit. A back-to-back restart begins the cycle after done, and the write to addr 0 during burst 1 is seen in burst 2.
